// File: rtl/mem_port_scheduler.sv
// Arbitrates the single physical-memory port between the icache and dcache.
// One line transaction at a time; dcache priority bounded by a starvation limit.
module mem_port_scheduler #(
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              busy,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] streak;

    logic d_req;
    logic both;
    logic grant_d;
    logic grant_i;

    // D wins contention until it has taken STARVE_LIMIT contested grants in a row
    always_comb begin
        d_req   = d_read | d_write;
        both    = d_req & i_read;
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            grant_d = d_req & (~i_read | (streak != STREAK_MAX));
            grant_i = i_read & ~grant_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            streak       <= '0;
            conflict_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (both && conflict_cnt != {CNT_W{1'b1}}) begin
                        conflict_cnt <= conflict_cnt + 1'b1;
                    end
                    if (grant_d) begin
                        state        <= D_BUSY;
                        pmem_address <= d_address;
                        pmem_write   <= d_write;
                        pmem_read    <= ~d_write;
                        if (d_write) begin
                            pmem_wdata <= d_wdata;
                        end
                        if (!i_read) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (grant_i) begin
                        state        <= I_BUSY;
                        pmem_address <= i_address;
                        pmem_read    <= 1'b1;
                        pmem_write   <= 1'b0;
                        streak       <= '0;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign i_resp = (state == I_BUSY) & pmem_resp;
    assign d_resp = (state == D_BUSY) & pmem_resp;
    assign rdata  = pmem_rdata;
    assign busy   = (state != IDLE);

endmodule
